// File: rtl/mips_mdu_pkg.sv
// Shared MDU definitions: op encoding and width, used by the MDU and by the
// decoder/controller for stall and mf/mt decode.
`timescale 1ns/1ps
package mips_mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MADD  = 3'd6,
    MDU_MSUB  = 3'd7
  } mdu_op_e;

  // How the pending product is folded into {hi,lo} at commit.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } mdu_acc_e;

endpackage

// File: rtl/mips_mdu_ctrl.sv
// Busy counter and commit strobe for the MDU; latency chosen per launch.
`timescale 1ns/1ps
module mips_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  input  logic is_div,
  output logic busy,
  output logic commit
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (launch) begin
      cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // The edge that takes cnt from 1 to 0 is the commit edge.
  assign busy   = (cnt != '0);
  assign commit = (cnt == CNT_ONE);

endmodule

// File: rtl/mips_mdu.sv
// Multiply/divide unit with HI/LO registers. Optional MADD/MSUB on ops 6/7
// when MIPS_MDU_MADD_EN is defined; otherwise those ops are no-ops.
`timescale 1ns/1ps
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  localparam int W  = DATA_W;
  localparam int W2 = 2 * DATA_W;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE_W    = W'(1);

  // Handshake: start is a one-cycle request honoured only while busy is low;
  // busy then stays high until the edge that commits hi/lo, and requests
  // arriving while busy is high are dropped.
  mdu_op_e op_e;
  logic    accept, launch, is_div, commit;

  assign op_e   = mdu_op_e'(op);
  assign accept = start & ~busy;

  always_comb begin
    launch = 1'b0;
    is_div = 1'b0;
    case (op_e)
      MDU_MULT, MDU_MULTU: launch = accept;
      MDU_DIV, MDU_DIVU: begin
        launch = accept;
        is_div = 1'b1;
      end
`ifdef MIPS_MDU_MADD_EN
      MDU_MADD, MDU_MSUB: launch = accept;
`endif
      default: launch = 1'b0;
    endcase
  end

  mips_mdu_ctrl #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .launch (launch),
    .is_div (is_div),
    .busy   (busy),
    .commit (commit)
  );

  logic signed [W2-1:0] prod_s;
  logic        [W2-1:0] prod_u;
  assign prod_s = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Zero and overflow divisors are swapped for 1 so the divider never sees
  // an undefined case; dividing by 1 also yields the overflow result (a, 0).
  logic               div_zero, div_ovf;
  logic signed [W-1:0] sdivisor, squot, srem;
  logic        [W-1:0] udivisor, uquot, urem;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1);
  assign sdivisor = (div_zero || div_ovf) ? $signed(ONE_W) : $signed(b);
  assign udivisor = div_zero ? ONE_W : b;
  assign squot    = $signed(a) / sdivisor;
  assign srem     = $signed(a) % sdivisor;
  assign uquot    = a / udivisor;
  assign urem     = a % udivisor;

  logic [W-1:0] res_hi, res_lo;
  mdu_acc_e     acc_next;

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    acc_next = ACC_NONE;
    case (op_e)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_lo = div_zero ? '1 : squot;
        res_hi = div_zero ? a  : srem;
      end
      MDU_DIVU: begin
        res_lo = div_zero ? '1 : uquot;
        res_hi = div_zero ? a  : urem;
      end
`ifdef MIPS_MDU_MADD_EN
      MDU_MADD: begin
        {res_hi, res_lo} = prod_s;
        acc_next         = ACC_ADD;
      end
      MDU_MSUB: begin
        {res_hi, res_lo} = prod_s;
        acc_next         = ACC_SUB;
      end
`endif
      default: ;
    endcase
  end

  logic [W-1:0] pend_hi, pend_lo;
  mdu_acc_e     pend_acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_acc <= ACC_NONE;
    end else begin
      if (launch) begin
        pend_hi  <= res_hi;
        pend_lo  <= res_lo;
        pend_acc <= acc_next;
      end
      // Commit only happens while busy, accept only while idle: never both.
      if (commit) begin
        case (pend_acc)
          ACC_ADD: {hi, lo} <= {hi, lo} + {pend_hi, pend_lo};
          ACC_SUB: {hi, lo} <= {hi, lo} - {pend_hi, pend_lo};
          default: {hi, lo} <= {pend_hi, pend_lo};
        endcase
      end else if (accept && op_e == MDU_MTHI) begin
        hi <= a;
      end else if (accept && op_e == MDU_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Self-checking bench for mips_mdu against a plain-arithmetic HI/LO model.
// Honours MIPS_MDU_MADD_EN the same way the design does.
`timescale 1ns/1ps
module tb_mips_mdu;

  localparam int DW = 32;
  localparam int MC = 5;
  localparam int DC = 10;
  localparam int LIMIT = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] a, b;
  logic          busy;
  logic [DW-1:0] hi, lo;

  mips_mdu #(.DATA_W(DW), .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: architectural HI/LO and the busy length of the last op.
  logic [DW-1:0] mdl_hi = '0;
  logic [DW-1:0] mdl_lo = '0;
  int            mdl_cyc = 0;
  logic [DW-1:0] exp_q[$];

  task automatic model_apply(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint        sx, sy;
    logic [63:0]   p;
    logic [DW-1:0] mx, my, q, r;
    mdl_cyc = 0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: begin p = sx * sy; {mdl_hi, mdl_lo} = p; mdl_cyc = MC; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; {mdl_hi, mdl_lo} = p; mdl_cyc = MC; end
      3'd2: begin
        mdl_cyc = DC;
        if (y == 0) begin
          mdl_lo = '1; mdl_hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          mdl_lo = x; mdl_hi = '0;
        end else begin
          mx = x[31] ? -x : x;
          my = y[31] ? -y : y;
          q = mx / my;
          r = mx % my;
          mdl_lo = (x[31] ^ y[31]) ? -q : q;
          mdl_hi = x[31] ? -r : r;
        end
      end
      3'd3: begin
        mdl_cyc = DC;
        if (y == 0) begin mdl_lo = '1; mdl_hi = x; end
        else begin mdl_lo = x / y; mdl_hi = x % y; end
      end
      3'd4: mdl_hi = x;
      3'd5: mdl_lo = x;
`ifdef MIPS_MDU_MADD_EN
      3'd6: begin p = sx * sy; {mdl_hi, mdl_lo} = {mdl_hi, mdl_lo} + p; mdl_cyc = MC; end
      3'd7: begin p = sx * sy; {mdl_hi, mdl_lo} = {mdl_hi, mdl_lo} - p; mdl_cyc = MC; end
`endif
      default: ;
    endcase
  endtask

  // Called just after a negedge; returns at the first negedge with busy low.
  task automatic run_op(input logic [2:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        output int cyc, output bit held);
    logic [DW-1:0] old_hi, old_lo;
    old_hi = mdl_hi;
    old_lo = mdl_lo;
    model_apply(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    cyc = 0;
    held = 1'b1;
    while (busy === 1'b1 && cyc < LIMIT) begin
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_vec++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_vec++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_mult();
    logic [2:0]    ops[6] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0};
    logic [DW-1:0] as[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, $urandom};
    logic [DW-1:0] bs[6]  = '{32'd3, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, $urandom};
    int cyc; bit held;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], cyc, held);
      n_vec++; if (cyc !== mdl_cyc) begin n_err++; $display("FAIL mult%0d_busy got=%0d exp=%0d", i, cyc, mdl_cyc); end
      n_vec++; if (!held) begin n_err++; $display("FAIL mult%0d_hold got=changed exp=stable", i); end
      n_vec++; if (hi !== mdl_hi) begin n_err++; $display("FAIL mult%0d_hi got=%h exp=%h", i, hi, mdl_hi); end
      n_vec++; if (lo !== mdl_lo) begin n_err++; $display("FAIL mult%0d_lo got=%h exp=%h", i, lo, mdl_lo); end
    end
  endtask

  task automatic test_div();
    logic [2:0]    ops[8] = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3};
    logic [DW-1:0] as[8]  = '{-32'sd7, 32'd7, 32'h1234_5678, 32'h8765_4321, 32'h8000_0000,
                              32'd7, $urandom, $urandom};
    logic [DW-1:0] bs[8]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, -32'sd2,
                              32'($urandom_range(1, 1000)) | 32'h8000_0000, 32'($urandom_range(1, 70000))};
    int cyc; bit held;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], cyc, held);
      n_vec++; if (cyc !== mdl_cyc) begin n_err++; $display("FAIL div%0d_busy got=%0d exp=%0d", i, cyc, mdl_cyc); end
      n_vec++; if (!held) begin n_err++; $display("FAIL div%0d_hold got=changed exp=stable", i); end
      n_vec++; if (hi !== mdl_hi) begin n_err++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, mdl_hi); end
      n_vec++; if (lo !== mdl_lo) begin n_err++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, mdl_lo); end
    end
  endtask

  task automatic test_move();
    int cyc; bit held;
    run_op(3'd4, 32'h1234, $urandom, cyc, held);
    n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL mthi_busy got=%0d exp=0", cyc); end
    n_vec++; if (hi !== mdl_hi) begin n_err++; $display("FAIL mthi_hi got=%h exp=%h", hi, mdl_hi); end
    n_vec++; if (lo !== mdl_lo) begin n_err++; $display("FAIL mthi_lo got=%h exp=%h", lo, mdl_lo); end
    run_op(3'd5, $urandom, $urandom, cyc, held);
    n_vec++; if (cyc !== 0) begin n_err++; $display("FAIL mtlo_busy got=%0d exp=0", cyc); end
    n_vec++; if (hi !== mdl_hi) begin n_err++; $display("FAIL mtlo_hi got=%h exp=%h", hi, mdl_hi); end
    n_vec++; if (lo !== mdl_lo) begin n_err++; $display("FAIL mtlo_lo got=%h exp=%h", lo, mdl_lo); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    model_apply(3'd0, 32'd1000, 32'd77);
    start = 1'b1; op = 3'd0; a = 32'd1000; b = 32'd77;
    @(negedge clk);
    // A second request while busy, including an MTHI that must not land.
    start = 1'b1; op = 3'd2; a = 32'd99; b = 32'd5;
    @(negedge clk);
    op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (busy === 1'b1 && cyc < LIMIT) begin cyc++; @(negedge clk); end
    n_vec++; if (cyc !== MC + 1) begin n_err++; $display("FAIL ignore_busy got=%0d exp=%0d", cyc, MC + 1); end
    n_vec++; if (hi !== mdl_hi) begin n_err++; $display("FAIL ignore_hi got=%h exp=%h", hi, mdl_hi); end
    n_vec++; if (lo !== mdl_lo) begin n_err++; $display("FAIL ignore_lo got=%h exp=%h", lo, mdl_lo); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit held;
    run_op(3'd3, 32'd1_000_003, 32'd10, cyc, held);
    n_vec++; if (lo !== mdl_lo) begin n_err++; $display("FAIL b2b_first_lo got=%h exp=%h", lo, mdl_lo); end
    run_op(3'd0, $urandom, $urandom, cyc, held);
    n_vec++; if (cyc !== MC) begin n_err++; $display("FAIL b2b_busy got=%0d exp=%0d", cyc, MC); end
    n_vec++; if (!held) begin n_err++; $display("FAIL b2b_hold got=changed exp=stable"); end
    n_vec++; if ({hi, lo} !== {mdl_hi, mdl_lo}) begin n_err++; $display("FAIL b2b_result got=%h%h exp=%h%h", hi, lo, mdl_hi, mdl_lo); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit held;
    run_op(3'd4, 32'h55, '0, cyc, held);
    start = 1'b1; op = 3'd0; a = 32'h7FFF_0001; b = 32'h0003_0007;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    n_vec++; if ({hi, lo} !== '0) begin n_err++; $display("FAIL abort_hilo got=%h%h exp=0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (MC + 3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_late_busy got=%0b exp=0", busy); end
    n_vec++; if ({hi, lo} !== '0) begin n_err++; $display("FAIL abort_late_hilo got=%h%h exp=0", hi, lo); end
  endtask

  task automatic test_madd();
    logic [2:0]    ops[4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    logic [DW-1:0] as[4]  = '{32'd0, 32'd10, 32'd3, 32'd5};
    logic [DW-1:0] bs[4]  = '{32'd0, 32'd0, 32'd4, 32'd5};
    int cyc; bit held;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], cyc, held);
      n_vec++; if (cyc !== mdl_cyc) begin n_err++; $display("FAIL madd%0d_busy got=%0d exp=%0d", i, cyc, mdl_cyc); end
      n_vec++; if ({hi, lo} !== {mdl_hi, mdl_lo}) begin n_err++; $display("FAIL madd%0d_hilo got=%h%h exp=%h%h", i, hi, lo, mdl_hi, mdl_lo); end
    end
  endtask

  task automatic test_random();
    logic [2:0]    o;
    logic [DW-1:0] x, y, eh, el;
    int cyc; bit held;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = '1;
        2: y = 32'($urandom_range(1, 300));
        default: y = $urandom;
      endcase
      run_op(o, x, y, cyc, held);
      exp_q.push_back(mdl_hi);
      exp_q.push_back(mdl_lo);
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      n_vec++; if (cyc !== mdl_cyc) begin n_err++; $display("FAIL rnd%0d_busy op=%0d got=%0d exp=%0d", i, o, cyc, mdl_cyc); end
      n_vec++; if (!held) begin n_err++; $display("FAIL rnd%0d_hold op=%0d got=changed exp=stable", i, o); end
      n_vec++; if (hi !== eh) begin n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, hi, eh); end
      n_vec++; if (lo !== el) begin n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, lo, el); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_madd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
